// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: word type, FSM state encoding,
// latency-counter width and the byte-lane merge / saturating-count helpers.
package data_mem_responder_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  localparam int CNT_W = 4;

  function automatic rv32i_word byte_merge(input rv32i_word old_w,
                                           input rv32i_word new_w,
                                           input logic [3:0] mbe);
    rv32i_word res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mbe[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  function automatic rv32i_word sat_inc(input rv32i_word v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response data port between the memory-access stage (master) and the
// data memory (slave).
interface data_mem_responder_if;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mbe;
  logic [31:0] data_rdata;
  logic        data_resp;

  modport master (
    output data_read, data_write, data_addr, data_wdata, data_mbe,
    input  data_rdata, data_resp
  );

  modport slave (
    input  data_read, data_write, data_addr, data_wdata, data_mbe,
    output data_rdata, data_resp
  );
endinterface

// File: rtl/data_mem_responder_sram.sv
// Single-port DEPTH x 32 word array with byte-enabled write and a registered
// read that returns the word as it was before a same-cycle write.
module data_sram
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  rv32i_word                wdata_i,
  input  logic [3:0]               mbe_i,
  output rv32i_word                rdata_o
);

  rv32i_word mem_q [DEPTH];
  rv32i_word rdata_q;

  // Array storage: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= byte_merge(mem_q[idx_i], wdata_i, mbe_i);
    end
  end

  // Read register: holds its value between accesses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else if (en_i) begin
      rdata_q <= mem_q[idx_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request in IDLE, waits LATENCY cycles,
// commits to the array and pulses data_resp for one cycle.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  output logic                 busy,
  output rv32i_word            rd_count,
  output rv32i_word            wr_count,
  output logic                 proto_err
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  resp_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             rd_q;
  logic             wr_q;
  rv32i_word        wdata_q;
  logic [3:0]       mbe_q;
  logic             resp_q;
  logic             busy_q;
  rv32i_word        rd_count_q;
  rv32i_word        wr_count_q;
  logic             perr_q;

  logic             req_s;
  logic             commit_d;
  rv32i_word        sram_rdata_s;
  logic             unused_addr_s;

  assign req_s         = bus.data_read | bus.data_write;
  assign unused_addr_s = ^{bus.data_addr[31:IDX_W+2], bus.data_addr[1:0]};

  // Array access strobe: last BUSY cycle with the request still held.
  always_comb begin
    commit_d = 1'b0;
    if (rst_n && (state_q == BUSY) && req_s && (cnt_q == {CNT_W{1'b0}})) begin
      commit_d = 1'b1;
    end else begin
      commit_d = 1'b0;
    end
  end

  // Responder FSM with request latches, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'd0;
      mbe_q      <= 4'd0;
      resp_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
      perr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (req_s) begin
            idx_q   <= bus.data_addr[IDX_W+1:2];
            rd_q    <= bus.data_read;
            wr_q    <= bus.data_write;
            wdata_q <= bus.data_wdata;
            mbe_q   <= bus.data_mbe;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= BUSY;
            if (bus.data_read && bus.data_write) begin
              perr_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!req_s) begin
            // Initiator abandoned the request: flag it, nothing is committed.
            perr_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == {CNT_W{1'b0}}) begin
            resp_q  <= 1'b1;
            state_q <= RESP;
            if (rd_q) begin
              rd_count_q <= sat_inc(rd_count_q);
            end
            if (wr_q) begin
              wr_count_q <= sat_inc(wr_count_q);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          resp_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          resp_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  data_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (commit_d),
    .we_i    (wr_q),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .mbe_i   (mbe_q),
    .rdata_o (sram_rdata_s)
  );

  assign bus.data_rdata = sram_rdata_s;
  assign bus.data_resp  = resp_q;
  assign busy           = busy_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;
  assign proto_err      = perr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder: a word-array reference
// model feeds a scoreboard queue that a negedge monitor drains on each data_resp.
module tb_data_mem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic        proto_err;

  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .proto_err (proto_err)
  );

  typedef struct {
    bit          chk;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] ref_mem [DEPTH];
  bit          written [DEPTH];
  int          m_rd = 0;
  int          m_wr = 0;
  bit          m_perr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a >> 2) % DEPTH;
  endfunction

  // Monitor: every response pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_resp === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data_resp=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        if (e.chk) chk("rdata", bus.data_rdata, e.rdata);
      end
    end
  end

  task automatic check_status();
    chk("rd_count", rd_count, 32'(m_rd));
    chk("wr_count", wr_count, 32'(m_wr));
    chk("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mbe, input bit b2b);
    exp_t        e;
    int          i;
    logic [31:0] m;
    i = widx(addr);
    bus.data_read  = rd;
    bus.data_write = wr;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
    bus.data_mbe   = mbe;
    e.chk   = rd;
    e.rdata = ref_mem[i];
    e.due   = cyc + LAT + 1 + (b2b ? 1 : 0);
    if (wr) begin
      m = {{8{mbe[3]}}, {8{mbe[2]}}, {8{mbe[1]}}, {8{mbe[0]}}};
      ref_mem[i] = (ref_mem[i] & ~m) | (wdata & m);
      written[i] = 1'b1;
    end
    if (rd) m_rd++;
    if (wr) m_wr++;
    if (rd && wr) m_perr = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    if (!b2b) chk("busy_after_accept", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 40 && bus.data_resp !== 1'b1; k++) @(negedge clk);
    if (bus.data_resp !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no data_resp in 40 cycles expected one");
      sb.delete();
    end
  endtask

  task automatic quiet();
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    @(negedge clk);
    check_status();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    int          i;
    int          op;
    bit          b2b;
    logic [3:0]  mbe;

    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    bus.data_addr  = 32'd0;
    bus.data_wdata = 32'd0;
    bus.data_mbe   = 4'd0;

    // Reset and idle.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_flags", {29'd0, bus.data_resp, busy, proto_err}, 32'd0);
    end
    chk("reset_rdata", bus.data_rdata, 32'd0);
    check_status();

    // Full write then read.
    txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0); quiet();
    txn(1'b1, 1'b0, 32'h0000_0010, 32'd0, 4'hF, 1'b0);        quiet();

    // Partial write over a known word.
    txn(1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 4'hF, 1'b0);  quiet();
    txn(1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 1'b0); quiet();
    txn(1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'hF, 1'b0);          quiet();

    // Aliased address, requests held back to back.
    txn(1'b0, 1'b1, 32'h0000_0404, 32'h0000_0005, 4'hF, 1'b0);
    txn(1'b1, 1'b0, 32'h0000_0004, 32'd0, 4'hF, 1'b1);
    quiet();

    // Read and write together: pre-write data returned, both counted.
    txn(1'b0, 1'b1, 32'h0000_0030, 32'h0000_0001, 4'hF, 1'b0); quiet();
    txn(1'b1, 1'b1, 32'h0000_0030, 32'h0000_0002, 4'hF, 1'b0); quiet();
    txn(1'b1, 1'b0, 32'h0000_0030, 32'd0, 4'hF, 1'b0);         quiet();

    // Read abandoned while BUSY.
    bus.data_read = 1'b1;
    bus.data_addr = 32'h0000_0030;
    @(negedge clk);
    bus.data_read = 1'b0;
    m_perr = 1'b1;
    @(negedge clk);
    chk("busy_after_drop", {31'd0, busy}, 32'd0);
    repeat (LAT + 2) @(negedge clk);
    check_status();

    // Reset during a write: no commit, counters cleared.
    txn(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'hF, 1'b0); quiet();
    bus.data_write = 1'b1;
    bus.data_addr  = 32'h0000_0040;
    bus.data_wdata = 32'hFFFF_FFFF;
    bus.data_mbe   = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.data_write = 1'b0;
    rst_n = 1'b1;
    m_rd = 0;
    m_wr = 0;
    m_perr = 1'b0;
    @(negedge clk);
    check_status();
    txn(1'b1, 1'b0, 32'h0000_0040, 32'd0, 4'hF, 1'b0); quiet();

    // Random mix over a small window of words with random alias bits.
    b2b = 1'b0;
    for (int n = 0; n < 60; n++) begin
      i    = $urandom_range(0, 15);
      addr = ($urandom() & ~32'h0000_03FF) | 32'(i << 2) | 32'($urandom_range(0, 3));
      op   = $urandom_range(0, 9);
      mbe  = 4'($urandom_range(0, 15));
      if (!written[i]) begin
        op  = 5;
        mbe = 4'hF;
      end
      txn(op <= 4 || op == 9, op >= 5, addr, $urandom(), mbe, b2b);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) quiet();
    end
    quiet();

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
